multicycle_controller: RTL and testbench

- Moore-style main control FSM for the multicycle RV32I datapath.
- It is the producer side of the ALUOp interface: it generates ALUOp[1:0] for the existing ALU decoder, along with all datapath strobes and mux selects.
- It sequences each instruction through fetch, decode, execute, memory and writeback states.
- Supported instructions: lw, sw, R-type ALU, I-type ALU, beq/bne, jal.

---
 rtl/multicycle_controller_if.sv | 71 +++++++
 rtl/multicycle_controller.sv | 257 +++++++++++++++++++++++++
 tb/tb_multicycle_controller.sv | 280 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/multicycle_controller_if.sv
// -----------------------------------------------------------------------------
// multicycle_controller_if
//
// Bundle of signals between the multicycle main controller and the RV32I
// datapath.
//
// Ports (by direction, seen from the controller):
//   inputs  : op[6:0]     instruction opcode (instr[6:0]) from the IR
//             funct3[2:0] instr[14:12]; bit 0 picks beq (0) / bne (1)
//             Zero        ALU zero flag
//   outputs : PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite     strobes/selects
//             ResultSrc[1:0], ALUSrcA[1:0], ALUSrcB[1:0]       mux selects
//             ALUOp[1:0]                                       to ALU decoder
//             ImmSrc[1:0]                                      immediate format
//
// There is no valid/ready handshake on this bundle. The controller steps one
// state per clock, and every output is a level that is meaningful for the
// whole cycle in which the controller presents it.
//
// Modports:
//   master : the controller (drives strobes, reads op/funct3/Zero)
//   slave  : the datapath   (drives op/funct3/Zero, reads strobes)
// -----------------------------------------------------------------------------
interface multicycle_controller_if;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       Zero;

  logic       PCWrite;
  logic       AdrSrc;
  logic       MemWrite;
  logic       IRWrite;
  logic       RegWrite;
  logic [1:0] ResultSrc;
  logic [1:0] ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [1:0] ALUOp;
  logic [1:0] ImmSrc;

  modport master (
    input  op,
    input  funct3,
    input  Zero,
    output PCWrite,
    output AdrSrc,
    output MemWrite,
    output IRWrite,
    output RegWrite,
    output ResultSrc,
    output ALUSrcA,
    output ALUSrcB,
    output ALUOp,
    output ImmSrc
  );

  modport slave (
    output op,
    output funct3,
    output Zero,
    input  PCWrite,
    input  AdrSrc,
    input  MemWrite,
    input  IRWrite,
    input  RegWrite,
    input  ResultSrc,
    input  ALUSrcA,
    input  ALUSrcB,
    input  ALUOp,
    input  ImmSrc
  );
endinterface

// File: rtl/multicycle_controller.sv
// -----------------------------------------------------------------------------
// multicycle_controller
//
// Moore-style main control FSM for the multicycle RV32I datapath. It walks
// each instruction through fetch, decode, execute, memory and writeback, and
// produces all datapath strobes, mux selects and the ALUOp code consumed by
// the ALU decoder.
//
// Supported: lw, sw, R-type ALU, I-type ALU, beq/bne, jal. Any other opcode
// is a NOP that returns to FETCH straight from DECODE.
//
// Ports:
//   clk     in   system clock, all state changes on the rising edge
//   reset   in   synchronous active-low reset
//   bus     --   multicycle_controller_if.master (op/funct3/Zero in,
//                strobes and selects out)
//   state_o out  current FSM state, for debug and checkers
//
// Cycles from FETCH to the next FETCH:
//   lw 5, sw 4, R 4, I 4, jal 4, beq/bne 3, unsupported 2.
// -----------------------------------------------------------------------------
module multicycle_controller #(
  parameter logic [3:0] RESET_STATE = 4'd0
) (
  input  logic                          clk,
  input  logic                          reset,
  multicycle_controller_if.master       bus,
  output logic [3:0]                    state_o
);

  // State encoding. Codes 11..15 are unused and recover to FETCH.
  localparam logic [3:0] S_FETCH    = 4'd0;
  localparam logic [3:0] S_DECODE   = 4'd1;
  localparam logic [3:0] S_MEMADR   = 4'd2;
  localparam logic [3:0] S_MEMREAD  = 4'd3;
  localparam logic [3:0] S_MEMWB    = 4'd4;
  localparam logic [3:0] S_MEMWRITE = 4'd5;
  localparam logic [3:0] S_EXECUTER = 4'd6;
  localparam logic [3:0] S_EXECUTEI = 4'd7;
  localparam logic [3:0] S_ALUWB    = 4'd8;
  localparam logic [3:0] S_BRANCH   = 4'd9;
  localparam logic [3:0] S_JAL      = 4'd10;

  // Opcodes the controller distinguishes.
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  // Mux-select encodings, named for readability of the output table.
  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;

  localparam logic [1:0] SRCB_RS2   = 2'b00;
  localparam logic [1:0] SRCB_IMM   = 2'b01;
  localparam logic [1:0] SRCB_FOUR  = 2'b10;

  localparam logic [1:0] ALUOP_ADD    = 2'b00;
  localparam logic [1:0] ALUOP_SUB    = 2'b01;
  localparam logic [1:0] ALUOP_DECODE = 2'b10;

  logic [3:0] state;
  logic [3:0] next_state;

  // While reset is held low the outputs show FETCH values, so decode the
  // outputs from this view of the state rather than from the register.
  logic [3:0] out_state;

  // Moore outputs before reset gating.
  logic       pc_update;
  logic       branch;
  logic       ir_write_m;
  logic       reg_write_m;
  logic       mem_write_m;
  logic       adr_src_m;
  logic [1:0] result_src_m;
  logic [1:0] alu_src_a_m;
  logic [1:0] alu_src_b_m;
  logic [1:0] alu_op_m;

  logic       branch_taken;

  // Only bit 0 of funct3 selects the branch sense; the upper bits are
  // deliberately ignored, so other funct3 values follow the same rule.
  logic       unused_funct3_hi;
  assign unused_funct3_hi = ^bus.funct3[2:1];

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= RESET_STATE;
    end else begin
      state <= next_state;
    end
  end

  assign state_o = state;

  // ---------------------------------------------------------------------------
  // Next-state logic. op is only consulted in DECODE and MEMADR; the IR is
  // stable for the whole instruction, so MEMADR can re-read it to split
  // loads from stores.
  // ---------------------------------------------------------------------------
  always_comb begin
    next_state = S_FETCH;
    case (state)
      S_FETCH: next_state = S_DECODE;
      S_DECODE: begin
        case (bus.op)
          OP_LOAD,
          OP_STORE:  next_state = S_MEMADR;
          OP_RTYPE:  next_state = S_EXECUTER;
          OP_ITYPE:  next_state = S_EXECUTEI;
          OP_BRANCH: next_state = S_BRANCH;
          OP_JAL:    next_state = S_JAL;
          default:   next_state = S_FETCH;
        endcase
      end
      S_MEMADR:   next_state = (bus.op == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
      S_MEMREAD:  next_state = S_MEMWB;
      S_MEMWB:    next_state = S_FETCH;
      S_MEMWRITE: next_state = S_FETCH;
      S_EXECUTER: next_state = S_ALUWB;
      S_EXECUTEI: next_state = S_ALUWB;
      S_ALUWB:    next_state = S_FETCH;
      S_BRANCH:   next_state = S_FETCH;
      S_JAL:      next_state = S_ALUWB;
      default:    next_state = S_FETCH;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Moore output table. Anything not set in a state stays 0, which also
  // covers the illegal codes.
  // ---------------------------------------------------------------------------
  assign out_state = reset ? state : S_FETCH;

  always_comb begin
    pc_update    = 1'b0;
    branch       = 1'b0;
    ir_write_m   = 1'b0;
    reg_write_m  = 1'b0;
    mem_write_m  = 1'b0;
    adr_src_m    = 1'b0;
    result_src_m = 2'b00;
    alu_src_a_m  = 2'b00;
    alu_src_b_m  = 2'b00;
    alu_op_m     = 2'b00;
    case (out_state)
      S_FETCH: begin
        // Read instruction at PC, and compute PC + 4 straight into PC.
        ir_write_m   = 1'b1;
        pc_update    = 1'b1;
        adr_src_m    = 1'b0;
        alu_src_a_m  = SRCA_PC;
        alu_src_b_m  = SRCB_FOUR;
        alu_op_m     = ALUOP_ADD;
        result_src_m = RES_ALURESULT;
      end
      S_DECODE: begin
        // Speculatively form OldPC + imm so BRANCH finds the target in ALUOut.
        alu_src_a_m  = SRCA_OLDPC;
        alu_src_b_m  = SRCB_IMM;
        alu_op_m     = ALUOP_ADD;
      end
      S_MEMADR: begin
        alu_src_a_m  = SRCA_RS1;
        alu_src_b_m  = SRCB_IMM;
        alu_op_m     = ALUOP_ADD;
      end
      S_MEMREAD: begin
        adr_src_m    = 1'b1;
        result_src_m = RES_ALUOUT;
      end
      S_MEMWB: begin
        result_src_m = RES_DATA;
        reg_write_m  = 1'b1;
      end
      S_MEMWRITE: begin
        adr_src_m    = 1'b1;
        result_src_m = RES_ALUOUT;
        mem_write_m  = 1'b1;
      end
      S_EXECUTER: begin
        alu_src_a_m  = SRCA_RS1;
        alu_src_b_m  = SRCB_RS2;
        alu_op_m     = ALUOP_DECODE;
      end
      S_EXECUTEI: begin
        alu_src_a_m  = SRCA_RS1;
        alu_src_b_m  = SRCB_IMM;
        alu_op_m     = ALUOP_DECODE;
      end
      S_ALUWB: begin
        result_src_m = RES_ALUOUT;
        reg_write_m  = 1'b1;
      end
      S_BRANCH: begin
        // Compare rs1 - rs2 while ALUOut still holds the target from DECODE.
        alu_src_a_m  = SRCA_RS1;
        alu_src_b_m  = SRCB_RS2;
        alu_op_m     = ALUOP_SUB;
        result_src_m = RES_ALUOUT;
        branch       = 1'b1;
      end
      S_JAL: begin
        // PC takes the jump target (ALUOut from DECODE); OldPC + 4 is
        // computed for the link register written in ALUWB.
        alu_src_a_m  = SRCA_OLDPC;
        alu_src_b_m  = SRCB_FOUR;
        alu_op_m     = ALUOP_ADD;
        result_src_m = RES_ALUOUT;
        pc_update    = 1'b1;
      end
      default: begin
        pc_update    = 1'b0;
      end
    endcase
  end

  // beq takes the branch on Zero, bne on !Zero.
  assign branch_taken = bus.Zero ^ bus.funct3[0];

  // Write strobes are held off for as long as reset is asserted.
  assign bus.PCWrite   = reset & (pc_update | (branch & branch_taken));
  assign bus.IRWrite   = reset & ir_write_m;
  assign bus.MemWrite  = reset & mem_write_m;
  assign bus.RegWrite  = reset & reg_write_m;

  assign bus.AdrSrc    = adr_src_m;
  assign bus.ResultSrc = result_src_m;
  assign bus.ALUSrcA   = alu_src_a_m;
  assign bus.ALUSrcB   = alu_src_b_m;
  assign bus.ALUOp     = alu_op_m;

  // ---------------------------------------------------------------------------
  // Immediate format follows the opcode alone, independent of state.
  // ---------------------------------------------------------------------------
  always_comb begin
    case (bus.op)
      OP_STORE:  bus.ImmSrc = 2'b01;
      OP_BRANCH: bus.ImmSrc = 2'b10;
      OP_JAL:    bus.ImmSrc = 2'b11;
      default:   bus.ImmSrc = 2'b00;
    endcase
  end

endmodule

// File: tb/tb_multicycle_controller.sv
// -----------------------------------------------------------------------------
// tb_multicycle_controller
//
// Directed bench for multicycle_controller. Each task drives one instruction
// class from FETCH and compares state_o and the relevant outputs per cycle
// against hand-written expected sequences.
// -----------------------------------------------------------------------------
module tb_multicycle_controller;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [3:0] state_o;

  always #5 clk = ~clk;

  multicycle_controller_if bus ();

  multicycle_controller dut (
    .clk     (clk),
    .reset   (reset),
    .bus     (bus),
    .state_o (state_o)
  );

  int tests_run    = 0;
  int tests_failed = 0;

  // Advance one clock; outputs are then observed 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------------------------------------------------------------------
  // Driver
  // ---------------------------------------------------------------------------
  task automatic drive(input logic [6:0] op, input logic [2:0] f3, input logic z);
    bus.op     = op;
    bus.funct3 = f3;
    bus.Zero   = z;
  endtask

  // ---------------------------------------------------------------------------
  // Tests
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    drive(7'b0000011, 3'b000, 1'b0);
    tick();
    tick();
    tests_run++;
    if (state_o !== 4'd0 || bus.IRWrite !== 1'b0 || bus.PCWrite !== 1'b0 ||
        bus.MemWrite !== 1'b0 || bus.RegWrite !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_init: state=%0d IRW=%b PCW=%b MW=%b RW=%b, want 0 0 0 0 0",
               state_o, bus.IRWrite, bus.PCWrite, bus.MemWrite, bus.RegWrite);
    end
    // Walk a lw into MEMREAD, then reset mid-instruction.
    reset = 1'b1;
    #1;
    tick();  // -> DECODE
    tick();  // -> MEMADR
    tick();  // -> MEMREAD
    tests_run++;
    if (state_o !== 4'd3) begin
      tests_failed++;
      $display("FAIL reset_reach_memread: state=%0d want 3", state_o);
    end
    reset = 1'b0;
    #1;
    tests_run++;
    if (bus.IRWrite !== 1'b0 || bus.PCWrite !== 1'b0 || bus.MemWrite !== 1'b0 ||
        bus.RegWrite !== 1'b0 || bus.AdrSrc !== 1'b0 || bus.ALUSrcB !== 2'b10 ||
        bus.ResultSrc !== 2'b10) begin
      tests_failed++;
      $display("FAIL reset_gating: IRW=%b PCW=%b MW=%b RW=%b Adr=%b SrcB=%b Res=%b, want 0 0 0 0 0 10 10",
               bus.IRWrite, bus.PCWrite, bus.MemWrite, bus.RegWrite, bus.AdrSrc,
               bus.ALUSrcB, bus.ResultSrc);
    end
    for (int i = 0; i < 2; i++) begin
      tick();
      tests_run++;
      if (state_o !== 4'd0 || bus.IRWrite !== 1'b0 || bus.PCWrite !== 1'b0) begin
        tests_failed++;
        $display("FAIL reset_hold[%0d]: state=%0d IRW=%b PCW=%b, want 0 0 0",
                 i, state_o, bus.IRWrite, bus.PCWrite);
      end
    end
    reset = 1'b1;
    #1;
    tests_run++;
    if (state_o !== 4'd0 || bus.IRWrite !== 1'b1 || bus.PCWrite !== 1'b1) begin
      tests_failed++;
      $display("FAIL reset_release: state=%0d IRW=%b PCW=%b, want 0 1 1",
               state_o, bus.IRWrite, bus.PCWrite);
    end
  endtask

  task automatic test_lw();
    logic [3:0] seq [6] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd0};
    drive(7'b0000011, 3'b010, 1'b0);
    #1;
    for (int i = 0; i < 6; i++) begin
      tests_run++;
      if (state_o !== seq[i] || bus.RegWrite !== (seq[i] == 4'd4) ||
          bus.MemWrite !== 1'b0 || bus.ImmSrc !== 2'b00) begin
        tests_failed++;
        $display("FAIL lw[%0d]: state=%0d RW=%b MW=%b Imm=%b, want %0d %b 0 00",
                 i, state_o, bus.RegWrite, bus.MemWrite, bus.ImmSrc, seq[i], seq[i] == 4'd4);
      end
      if (seq[i] == 4'd4) begin
        tests_run++;
        if (bus.ResultSrc !== 2'b01) begin
          tests_failed++;
          $display("FAIL lw_memwb_resultsrc: got %b want 01", bus.ResultSrc);
        end
      end
      if (seq[i] == 4'd1) begin
        tests_run++;
        if (bus.ALUSrcA !== 2'b01 || bus.ALUSrcB !== 2'b01 || bus.ALUOp !== 2'b00 ||
            bus.PCWrite !== 1'b0) begin
          tests_failed++;
          $display("FAIL lw_decode_outputs: SrcA=%b SrcB=%b ALUOp=%b PCW=%b, want 01 01 00 0",
                   bus.ALUSrcA, bus.ALUSrcB, bus.ALUOp, bus.PCWrite);
        end
      end
      if (i < 5) tick();
    end
  endtask

  task automatic test_sw();
    logic [3:0] seq [5] = '{4'd0, 4'd1, 4'd2, 4'd5, 4'd0};
    drive(7'b0100011, 3'b010, 1'b0);
    #1;
    for (int i = 0; i < 5; i++) begin
      tests_run++;
      if (state_o !== seq[i] || bus.MemWrite !== (seq[i] == 4'd5) ||
          bus.RegWrite !== 1'b0 || bus.ImmSrc !== 2'b01) begin
        tests_failed++;
        $display("FAIL sw[%0d]: state=%0d MW=%b RW=%b Imm=%b, want %0d %b 0 01",
                 i, state_o, bus.MemWrite, bus.RegWrite, bus.ImmSrc, seq[i], seq[i] == 4'd5);
      end
      if (seq[i] == 4'd5) begin
        tests_run++;
        if (bus.AdrSrc !== 1'b1) begin
          tests_failed++;
          $display("FAIL sw_adrsrc: got %b want 1", bus.AdrSrc);
        end
      end
      if (i < 4) tick();
    end
  endtask

  task automatic test_alu();
    logic [6:0] ops  [2] = '{7'b0110011, 7'b0010011};
    logic [3:0] exst [2] = '{4'd6, 4'd7};
    logic [1:0] srcb [2] = '{2'b00, 2'b01};
    for (int k = 0; k < 2; k++) begin
      drive(ops[k], 3'b000, 1'b0);
      #1;
      for (int i = 0; i < 5; i++) begin
        logic [3:0] exp_s;
        case (i)
          0: exp_s = 4'd0;
          1: exp_s = 4'd1;
          2: exp_s = exst[k];
          3: exp_s = 4'd8;
          default: exp_s = 4'd0;
        endcase
        tests_run++;
        if (state_o !== exp_s || bus.RegWrite !== (i == 3) || bus.MemWrite !== 1'b0) begin
          tests_failed++;
          $display("FAIL alu%0d[%0d]: state=%0d RW=%b MW=%b, want %0d %b 0",
                   k, i, state_o, bus.RegWrite, bus.MemWrite, exp_s, i == 3);
        end
        if (i == 2) begin
          tests_run++;
          if (bus.ALUOp !== 2'b10 || bus.ALUSrcB !== srcb[k] || bus.ALUSrcA !== 2'b10) begin
            tests_failed++;
            $display("FAIL alu%0d_exec: ALUOp=%b SrcB=%b SrcA=%b, want 10 %b 10",
                     k, bus.ALUOp, bus.ALUSrcB, bus.ALUSrcA, srcb[k]);
          end
        end
        if (i < 4) tick();
      end
    end
  endtask

  task automatic test_branch();
    logic [2:0] f3  [4] = '{3'b000, 3'b000, 3'b001, 3'b001};
    logic       z   [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    logic       pcw [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    for (int k = 0; k < 4; k++) begin
      drive(7'b1100011, f3[k], z[k]);
      #1;
      tick();  // DECODE
      tick();  // BRANCH
      tests_run++;
      if (state_o !== 4'd9 || bus.PCWrite !== pcw[k] || bus.ALUOp !== 2'b01 ||
          bus.ImmSrc !== 2'b10 || bus.RegWrite !== 1'b0 || bus.MemWrite !== 1'b0) begin
        tests_failed++;
        $display("FAIL branch%0d: state=%0d PCW=%b ALUOp=%b Imm=%b RW=%b MW=%b, want 9 %b 01 10 0 0",
                 k, state_o, bus.PCWrite, bus.ALUOp, bus.ImmSrc, bus.RegWrite,
                 bus.MemWrite, pcw[k]);
      end
      tick();
      tests_run++;
      if (state_o !== 4'd0) begin
        tests_failed++;
        $display("FAIL branch%0d_return: state=%0d want 0", k, state_o);
      end
    end
  endtask

  task automatic test_jal();
    logic [3:0] seq [5] = '{4'd0, 4'd1, 4'd10, 4'd8, 4'd0};
    drive(7'b1101111, 3'b000, 1'b0);
    #1;
    for (int i = 0; i < 5; i++) begin
      tests_run++;
      if (state_o !== seq[i] || bus.ImmSrc !== 2'b11 || bus.RegWrite !== (seq[i] == 4'd8) ||
          bus.MemWrite !== 1'b0) begin
        tests_failed++;
        $display("FAIL jal[%0d]: state=%0d Imm=%b RW=%b MW=%b, want %0d 11 %b 0",
                 i, state_o, bus.ImmSrc, bus.RegWrite, bus.MemWrite, seq[i], seq[i] == 4'd8);
      end
      if (seq[i] == 4'd10) begin
        tests_run++;
        if (bus.PCWrite !== 1'b1 || bus.ALUSrcA !== 2'b01 || bus.ALUSrcB !== 2'b10) begin
          tests_failed++;
          $display("FAIL jal_state10: PCW=%b SrcA=%b SrcB=%b, want 1 01 10",
                   bus.PCWrite, bus.ALUSrcA, bus.ALUSrcB);
        end
      end
      if (i < 4) tick();
    end
  endtask

  task automatic test_nop();
    logic [3:0] seq [3] = '{4'd0, 4'd1, 4'd0};
    drive(7'b1111111, 3'b000, 1'b1);
    #1;
    for (int i = 0; i < 3; i++) begin
      tests_run++;
      if (state_o !== seq[i] || bus.RegWrite !== 1'b0 || bus.MemWrite !== 1'b0 ||
          bus.ImmSrc !== 2'b00) begin
        tests_failed++;
        $display("FAIL nop[%0d]: state=%0d RW=%b MW=%b Imm=%b, want %0d 0 0 00",
                 i, state_o, bus.RegWrite, bus.MemWrite, bus.ImmSrc, seq[i]);
      end
      if (seq[i] == 4'd1) begin
        tests_run++;
        if (bus.PCWrite !== 1'b0 || bus.IRWrite !== 1'b0) begin
          tests_failed++;
          $display("FAIL nop_decode_strobes: PCW=%b IRW=%b, want 0 0", bus.PCWrite, bus.IRWrite);
        end
      end
      if (i < 2) tick();
    end
  endtask

  // ---------------------------------------------------------------------------
  // Sequence and final report
  // ---------------------------------------------------------------------------
  initial begin
    drive(7'b0000000, 3'b000, 1'b0);
    test_reset();
    test_lw();
    test_sw();
    test_alu();
    test_branch();
    test_jal();
    test_nop();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
